dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have a single clock, and its reset SHALL be synchronous and active-high, with the following port list:
  - clk  in  1  single clock, all state on rising edge
  - rst  in  1  synchronous, active-high reset
  - req_valid  in  1  request present
  - req_ready  out  1  block can accept a request this cycle
  - req_we  in  1  1=store, 0=load
  - req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
  - req_addr  in  32  byte address; bits [14:2] = word index, [1:0] = lane offset, [31:15] ignored (aliasing)
  - req_wdata  in  32  store data, lane-aligned by requester (byte k on bits [8k+7:8k])
  - rsp_valid  out  1  response present
  - rsp_ready  in  1  requester accepts response
  - rsp_rdata  out  32  raw 32-bit word read from the addressed word (lanes 3..0); 0 for stores
  - rsp_err  out  1  misaligned/illegal request flag (see Configuration)

Function
REQ-002 The storage SHALL be 8192 words x 4 independent byte lanes (32 KiB), with no content initialisation.
REQ-003 The FSM SHALL have the states IDLE, RD, RESP; req_ready SHALL equal (state==IDLE) and SHALL be combinational from state only.
REQ-004 A request SHALL be accepted on a rising edge where req_valid && req_ready; req_addr, req_size and req_we SHALL be captured on that edge.
REQ-005 For an accepted store, the enabled lanes SHALL be written on the accept edge, and the state SHALL go IDLE->RESP.
REQ-006 The store lane enables SHALL be: byte -> lane = offset; half at offset 00 -> lanes 0,1; half at offset 10 -> lanes 2,3; word at offset 00 -> lanes 0-3; all other combinations -> no lane written.
REQ-007 For an accepted load, the state SHALL go IDLE->RD, the array SHALL be read on the next edge into a registered word, and the state SHALL then go RD->RESP.
REQ-008 Latency SHALL be: store response valid 1 cycle after accept; load response valid 2 cycles after accept.
REQ-009 In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL be held stable until rsp_valid && rsp_ready; on that edge the state SHALL go RESP->IDLE.
REQ-010 There SHALL be no back-to-back acceptance: at least one IDLE cycle SHALL occur between a response handshake and the next accept.
REQ-011 A load response SHALL return the full addressed word regardless of size/offset; the requester performs lane extraction and sign extension.
REQ-012 A load issued after a store to the same word SHALL return the post-store data (the write commits before any later read).
REQ-013 req_* inputs SHALL be ignored outside IDLE, and rsp_ready SHALL be ignored outside RESP.
REQ-014 A size of 11 SHALL be treated as misaligned for both loads and stores.

Reset
REQ-015 When rst is high on a rising edge: state SHALL go to IDLE, rsp_valid SHALL be 0, rsp_rdata SHALL be 0, rsp_err SHALL be 0, and req_ready SHALL be 1 in the following cycle.
REQ-016 Reset in RD or RESP SHALL drop the pending response; a store already committed SHALL remain in the array; array contents SHALL never be cleared by reset.
REQ-017 If rst and req_valid are both high on the same edge, reset SHALL win and the request SHALL NOT be accepted or written.

Configuration
REQ-018 The macro DMEM_MISALIGN_TRAP_EN SHALL control misalignment trapping as follows:
  - Defined: a misaligned request (per REQ-006/REQ-014) writes nothing, skips RD (goes IDLE->RESP directly), and responds with rsp_err=1 and rsp_rdata=0, 1 cycle after accept.
  - Undefined: rsp_err SHALL be tied to 0; a misaligned store writes nothing but is acknowledged normally; a misaligned load follows the normal RD path and returns the raw word.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Store word 0xDEADBEEF @0x0000_0010, then load word @0x10 -> store rsp after 1 cycle with rdata=0; load rsp 2 cycles after accept with rdata=0xDEADBEEF, err=0.
  - Store byte 0xAB on bits[23:16] @0x12 over 0x11223344 @0x10, then load -> rdata=0x11AB3344.
  - Store half @0x13 with trap defined -> rsp_err=1 at 1 cycle, word unchanged; with trap undefined -> err=0, word unchanged.
  - Load response with rsp_ready low for 5 cycles -> rsp_valid and rdata stable for all 6 cycles, req_ready=0 throughout, returns to IDLE one cycle after the handshake.
  - Assert rst during RD of a load @0x20 -> no rsp_valid appears; a prior store to 0x20 is still readable after reset.
  - Store to 0x0000_8010, then load 0x10 -> aliasing: the load returns the stored value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-port 32 KiB data memory (8192 words x 4 byte lanes) behind a
//   valid/ready request channel and a valid/ready response channel.
//   Requests are accepted one at a time; a store writes its lanes on the
//   accept edge and responds one cycle later, and a load reads the array
//   one edge later and responds two cycles after accept.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned requests write nothing, skip RD and respond with
//               rsp_err=1, rsp_rdata=0 one cycle after accept.
//   undefined : rsp_err is tied low; misaligned stores write nothing and are
//               acknowledged normally, misaligned loads return the raw word.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   synchronous active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   high while IDLE
//   req_we     in   1   1 = store, 0 = load
//   req_size   in   2   00 byte, 01 half, 10 word, 11 illegal
//   req_addr   in  32   byte address; [14:2] word index, [1:0] lane offset
//   req_wdata  in  32   lane-aligned store data
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   requester accepts response
//   rsp_rdata  out 32   addressed word for loads, 0 for stores
//   rsp_err    out  1   misaligned/illegal flag (trap build only)
//
// FSM states
//   state | meaning
//   IDLE  | ready for a request
//   RD    | load accepted, array read into the response register this edge
//   RESP  | response held until rsp_valid && rsp_ready

module dmem_responder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [12:0] idx_q, idx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        rsp_err_q, rsp_err_d;
  logic        mis;
`endif

  logic [31:0] mem_q [0:8191];

  logic [3:0]  lane_en;
  logic        accept;
  logic [12:0] req_idx;
  logic [16:0] unused_addr_hi;

  // Upper address bits alias onto the same 32 KiB.
  assign unused_addr_hi = req_addr[31:15];
  assign req_idx        = req_addr[14:2];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Store lane enables; an all-zero mask marks a misaligned/illegal request.
  always_comb begin
    lane_en = 4'b0000;
    unique case (req_size)
      2'b00: lane_en = 4'b0001 << req_addr[1:0];
      2'b01: begin
        if (req_addr[1:0] == 2'b00)      lane_en = 4'b0011;
        else if (req_addr[1:0] == 2'b10) lane_en = 4'b1100;
        else                             lane_en = 4'b0000;
      end
      2'b10: lane_en = (req_addr[1:0] == 2'b00) ? 4'b1111 : 4'b0000;
      default: lane_en = 4'b0000;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (lane_en == 4'b0000);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d       = req_idx;
          rsp_rdata_d = 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
          rsp_err_d   = 1'b0;
`endif
          if (req_we) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
            rsp_err_d   = mis;
`endif
          end else begin
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
            end else begin
              state_d = RD;
            end
`else
            state_d = RD;
`endif
          end
        end
      end
      RD: begin
        // Any store has already committed on its accept edge, so this read
        // always sees post-store data.
        rsp_rdata_d = mem_q[idx_q];
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 13'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
`ifdef DMEM_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Array has no reset; a request coinciding with rst is not written.
  always_ff @(posedge clk) begin
    if (!rst && accept && req_we) begin
      if (lane_en[0]) mem_q[req_idx][7:0]   <= req_wdata[7:0];
      if (lane_en[1]) mem_q[req_idx][15:8]  <= req_wdata[15:8];
      if (lane_en[2]) mem_q[req_idx][23:16] <= req_wdata[23:16];
      if (lane_en[3]) mem_q[req_idx][31:24] <= req_wdata[31:24];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
